// File: rtl/rr_arb4_fsm_if.sv
// Request/grant bundle between four clients and the round-robin arbiter.
// master: client side driving req; slave: arbiter side driving grants.
interface rr_arb4_fsm_if;
    logic [3:0] req;
    logic [3:0] grant;
    logic [1:0] gnt_id;
    logic       gnt_valid;
    logic       busy_other;
    logic       preempt;

    modport master (
        output req,
        input  grant,
        input  gnt_id,
        input  gnt_valid,
        input  busy_other,
        input  preempt
    );

    modport slave (
        input  req,
        output grant,
        output gnt_id,
        output gnt_valid,
        output busy_other,
        output preempt
    );
endinterface

// File: rtl/rr_arb4_fsm.sv
// Four-client round-robin arbiter, two-state Moore FSM, registered outputs.
// Define ARB_TIMEOUT_EN to revoke an owner after HOLD_MAX cycles when others wait.
module rr_arb4_fsm #(
    parameter int HOLD_MAX = 15,
    parameter int CNT_W    = 8
) (
    input logic         clk,
    input logic         rst,
    rr_arb4_fsm_if.slave bus
);

    typedef enum logic {
        IDLE,
        GRANT
    } state_t;

    state_t     state_q;
    state_t     state_d;
    logic [1:0] ptr_q;
    logic [1:0] ptr_d;
    logic [1:0] id_q;
    logic [1:0] id_d;
    logic [3:0] grant_q;
    logic [3:0] grant_d;
    logic       busy_q;
    logic       busy_d;

    logic [3:0] req;
    logic [3:0] owner_oh;
    logic [3:0] others;
    logic [3:0] cand;
    logic       take;
    logic       expire;
    logic [1:0] win;

    assign req      = bus.req;
    assign owner_oh = 4'b0001 << id_q;
    assign others   = req & ~owner_oh;

    // First set bit of r scanning upward from p, wrapping 3 -> 0.
    function automatic logic [1:0] pick(
        input logic [3:0] r,
        input logic [1:0] p
    );
        logic [1:0] idx;
        logic [1:0] w;
        logic       hit;
        w   = p;
        hit = 1'b0;
        for (int i = 0; i < 4; i++) begin
            idx = p + 2'(i);
            if (!hit && r[idx]) begin
                w   = idx;
                hit = 1'b1;
            end
        end
        return w;
    endfunction

`ifdef ARB_TIMEOUT_EN
    localparam logic [CNT_W-1:0] CNT_MAX = '1;
    localparam logic [CNT_W-1:0] LIMIT   = CNT_W'(HOLD_MAX - 1);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;
    logic             pre_q;

    // Saturating compare so a late waiter still triggers revocation.
    assign expire = (state_q == GRANT) && req[id_q]
                  && (|others) && (cnt_q >= LIMIT);
`else
    logic [CNT_W-1:0] cfg_unused;

    assign cfg_unused = CNT_W'(HOLD_MAX);
    assign expire     = 1'b0;
`endif

    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        id_d    = id_q;
        grant_d = grant_q;
        cand    = 4'b0000;
        take    = 1'b0;
        win     = 2'b00;

        unique case (state_q)
            IDLE: begin
                if (|req) begin
                    cand = req;
                    take = 1'b1;
                end
            end
            GRANT: begin
                if (expire) begin
                    cand = others;
                    take = 1'b1;
                end else if (!req[id_q]) begin
                    if (|others) begin
                        cand = others;
                        take = 1'b1;
                    end else begin
                        state_d = IDLE;
                        grant_d = 4'b0000;
                        id_d    = 2'b00;
                    end
                end
            end
        endcase

        if (take) begin
            win     = pick(cand, ptr_q);
            state_d = GRANT;
            id_d    = win;
            grant_d = 4'b0001 << win;
            ptr_d   = win + 2'd1;
        end

        busy_d = (state_d == GRANT) && (|(req & ~grant_d));
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            ptr_q   <= 2'b00;
            id_q    <= 2'b00;
            grant_q <= 4'b0000;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            id_q    <= id_d;
            grant_q <= grant_d;
            busy_q  <= busy_d;
        end
    end

`ifdef ARB_TIMEOUT_EN
    always_comb begin
        cnt_d = cnt_q;
        if (take || state_d == IDLE) begin
            cnt_d = '0;
        end else if (cnt_q != CNT_MAX) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
            pre_q <= 1'b0;
        end else begin
            cnt_q <= cnt_d;
            pre_q <= expire;
        end
    end

    assign bus.preempt = pre_q;
`else
    assign bus.preempt = 1'b0;
`endif

    assign bus.grant      = grant_q;
    assign bus.gnt_id     = id_q;
    assign bus.gnt_valid  = |grant_q;
    assign bus.busy_other = busy_q;

endmodule
